// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter
// One shift step per cycle; a sticky carry out of the top digit flags operands >= 10^D.
module bin2bcd_seq #(
  parameter int W = 6,
  parameter int D = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   valoare_bin,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd,
  output logic           overflow
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t         state;
  logic [W-1:0]   operand;
  logic [W-1:0]   operand_next;
  logic [4*D-1:0] work;
  logic [4*D-1:0] adj;
  logic [4*D-1:0] work_next;
  logic [CW-1:0]  cnt;
  logic           sticky;
  logic           carry_out;

  // Adjust digits >= 5 before the shift so each digit stays a legal BCD code.
  always_comb begin
    adj = work;
    for (int i = 0; i < D; i++) begin
      if (work[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
    carry_out    = adj[4*D-1];
    work_next    = {adj[4*D-2:0], operand[W-1]};
    operand_next = operand << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      operand  <= '0;
      work     <= '0;
      cnt      <= '0;
      sticky   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            operand <= valoare_bin;
            work    <= '0;
            sticky  <= 1'b0;
            cnt     <= CW'(W);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          work    <= work_next;
          operand <= operand_next;
          sticky  <= sticky | carry_out;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= LATCH;
        end
        LATCH: begin
          bcd      <= sticky ? {D{4'h9}} : work;
          overflow <= sticky;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed bench for bin2bcd_seq
// Three instances cover W=6/D=2, W=6/D=1 and W=16/D=5.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [5:0]  val_a = '0, val_b = '0;
  logic [15:0] val_c = '0;
  logic        busy_a, done_a, overflow_a;
  logic        busy_b, done_b, overflow_b;
  logic        busy_c, done_c, overflow_c;
  logic [7:0]  bcd_a;
  logic [3:0]  bcd_b;
  logic [19:0] bcd_c;

  bin2bcd_seq #(.W(6), .D(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .valoare_bin(val_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(overflow_a));

  bin2bcd_seq #(.W(6), .D(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .valoare_bin(val_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(overflow_b));

  bin2bcd_seq #(.W(16), .D(5)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .valoare_bin(val_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(overflow_c));

  int pass_cnt = 0;
  int total_cnt = 0;
  int sel = 0;

  logic        s_done, s_busy, s_ovf;
  logic [19:0] s_bcd;
  always_comb begin
    s_done = done_a; s_busy = busy_a; s_ovf = overflow_a; s_bcd = {12'b0, bcd_a};
    if (sel == 1) begin
      s_done = done_b; s_busy = busy_b; s_ovf = overflow_b; s_bcd = {16'b0, bcd_b};
    end else if (sel == 2) begin
      s_done = done_c; s_busy = busy_c; s_ovf = overflow_c; s_bcd = bcd_c;
    end
  end

  // Called at a negedge; returns at the negedge where done is high.
  task automatic run(input int which, input logic [15:0] v, output int lat, output int bcyc,
                     output logic [19:0] b, output logic o);
    sel = which;
    case (which)
      0: begin start_a = 1'b1; val_a = v[5:0]; end
      1: begin start_b = 1'b1; val_b = v[5:0]; end
      default: begin start_c = 1'b1; val_c = v; end
    endcase
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    lat = 0;
    bcyc = 0;
    while (!s_done && lat < 100) begin
      if (s_busy) bcyc++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    b = s_bcd;
    o = s_ovf;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a); else pass_cnt++;
    total_cnt++; if (done_a !== 1'b0) $display("FAIL reset_done got %b want 0", done_a); else pass_cnt++;
    total_cnt++; if (bcd_a !== 8'h00) $display("FAIL reset_bcd got %h want 00", bcd_a); else pass_cnt++;
    total_cnt++; if (overflow_a !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow_a); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bcyc;
    logic [19:0] b;
    logic o;
    run(0, 16'd59, lat, bcyc, b, o);
    total_cnt++; if (lat != 7) $display("FAIL basic_latency got %0d want 7", lat); else pass_cnt++;
    total_cnt++; if (bcyc != 7) $display("FAIL basic_busy_cycles got %0d want 7", bcyc); else pass_cnt++;
    total_cnt++; if (b[7:0] !== 8'h59) $display("FAIL basic_bcd got %h want 59", b[7:0]); else pass_cnt++;
    total_cnt++; if (o !== 1'b0) $display("FAIL basic_ovf got %b want 0", o); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done_a !== 1'b0) $display("FAIL done_one_cycle got %b want 0", done_a); else pass_cnt++;
    total_cnt++; if (bcd_a !== 8'h59) $display("FAIL bcd_hold got %h want 59", bcd_a); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] ops [4] = '{16'd0, 16'd9, 16'd10, 16'd63};
    logic [7:0]  exp [4] = '{8'h00, 8'h09, 8'h10, 8'h63};
    int lat, bcyc;
    logic [19:0] b;
    logic o;
    for (int i = 0; i < 4; i++) begin
      run(0, ops[i], lat, bcyc, b, o);
      total_cnt++;
      if (b[7:0] !== exp[i] || o !== 1'b0 || lat != 7)
        $display("FAIL b2b_%0d got bcd=%h ovf=%b lat=%0d want bcd=%h ovf=0 lat=7", i, b[7:0], o, lat, exp[i]);
      else pass_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic test_overflow_d1;
    int lat, bcyc;
    logic [19:0] b;
    logic o;
    run(1, 16'd12, lat, bcyc, b, o);
    total_cnt++; if (b[3:0] !== 4'h9) $display("FAIL d1_sat_bcd got %h want 9", b[3:0]); else pass_cnt++;
    total_cnt++; if (o !== 1'b1) $display("FAIL d1_sat_ovf got %b want 1", o); else pass_cnt++;
    run(1, 16'd7, lat, bcyc, b, o);
    total_cnt++; if (b[3:0] !== 4'h7) $display("FAIL d1_bcd got %h want 7", b[3:0]); else pass_cnt++;
    total_cnt++; if (o !== 1'b0) $display("FAIL d1_ovf got %b want 0", o); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int lat, dones, first_lat;
    logic [7:0] got;
    dones = 0; first_lat = 0; got = 8'h00;
    start_a = 1'b1; val_a = 6'd45;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0; val_a = 6'd17;
    lat = 0;
    repeat (30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 2) start_a = 1'b1;
      if (lat == 3) start_a = 1'b0;
      if (done_a) begin
        dones++;
        if (dones == 1) begin first_lat = lat; got = bcd_a; end
      end
    end
    total_cnt++; if (dones != 1) $display("FAIL ignore_done_count got %0d want 1", dones); else pass_cnt++;
    total_cnt++; if (first_lat != 7) $display("FAIL ignore_latency got %0d want 7", first_lat); else pass_cnt++;
    total_cnt++; if (got !== 8'h45) $display("FAIL ignore_bcd got %h want 45", got); else pass_cnt++;
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL ignore_idle_busy got %b want 0", busy_a); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int lat, bcyc, seen;
    logic [19:0] b;
    logic o;
    start_a = 1'b1; val_a = 6'd33;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy_a); else pass_cnt++;
    total_cnt++; if (bcd_a !== 8'h00) $display("FAIL midrst_bcd got %h want 00", bcd_a); else pass_cnt++;
    total_cnt++; if (done_a !== 1'b0 || overflow_a !== 1'b0)
      $display("FAIL midrst_flags got done=%b ovf=%b want 0 0", done_a, overflow_a); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin @(negedge clk); if (done_a || busy_a) seen = 1; end
    total_cnt++; if (seen != 0) $display("FAIL midrst_no_done got %0d want 0", seen); else pass_cnt++;
    run(0, 16'd21, lat, bcyc, b, o);
    total_cnt++; if (b[7:0] !== 8'h21 || lat != 7)
      $display("FAIL after_rst got bcd=%h lat=%0d want 21 7", b[7:0], lat); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_wide;
    int lat, bcyc;
    logic [19:0] b;
    logic o;
    run(2, 16'd65535, lat, bcyc, b, o);
    total_cnt++; if (lat != 17) $display("FAIL wide_latency got %0d want 17", lat); else pass_cnt++;
    total_cnt++; if (b !== 20'h65535) $display("FAIL wide_bcd got %h want 65535", b); else pass_cnt++;
    total_cnt++; if (o !== 1'b0) $display("FAIL wide_ovf got %b want 0", o); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_sweep;
    int lat, bcyc;
    logic [19:0] b;
    logic o;
    logic [7:0] exp;
    for (int v = 0; v < 64; v++) begin
      exp = {4'(v / 10), 4'(v % 10)};
      run(0, 16'(v), lat, bcyc, b, o);
      total_cnt++;
      if (b[7:0] !== exp || o !== 1'b0 || lat != 7)
        $display("FAIL sweep_%0d got bcd=%h ovf=%b lat=%0d want %h 0 7", v, b[7:0], o, lat, exp);
      else pass_cnt++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow_d1();
    test_ignore_start();
    test_reset_mid();
    test_wide();
    test_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
